adder_accum_core: RTL and testbench

Compute core directly downstream of the Adder AXI4-Lite slave register file. It sums a bias and a configured number of signed operand words received over a valid/ready stream. It returns one saturated result, with an overflow flag, over a valid/ready output that the register file captures into its readback register. Intended for bias-plus-partial-sum accumulation in the CNN datapath.

---
 rtl/adder_pkg.sv | 19 +
 rtl/adder_sat.sv | 25 ++
 rtl/adder_accum_core.sv | 117 +++++++++++
 tb/tb_adder_accum_core.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared widths, FSM state encoding and result type for the adder accumulate core.
package adder_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 16;
  localparam int ACC_WIDTH_DEF  = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      ovf;
  } result_t;

endpackage

// File: rtl/adder_sat.sv
// Combinational clamp of a wide signed accumulator into the signed result width.
module adder_sat #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 48
) (
  input  logic [ACC_WIDTH-1:0]  acc_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ovf_o
);

  // The value fits when every bit from the result sign bit upward equals the accumulator sign.
  logic [ACC_WIDTH-DATA_WIDTH:0] upper;
  assign upper = acc_i[ACC_WIDTH-1:DATA_WIDTH-1];

  always_comb begin
    data_o = acc_i[DATA_WIDTH-1:0];
    ovf_o  = 1'b0;
    if (upper != {(ACC_WIDTH-DATA_WIDTH+1){acc_i[ACC_WIDTH-1]}}) begin
      ovf_o  = 1'b1;
      data_o = acc_i[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                  : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/adder_accum_core.sv
// Bias-plus-operand accumulator: sums a configured number of stream beats and returns one saturated result.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
module adder_accum_core
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic [DATA_WIDTH-1:0] cfg_bias,
  input  logic                  start,
  output logic                  busy,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_ovf,
  output logic [1:0]            dbg_state_o
);

  state_e                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic                  busy_q, busy_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_ovf_q, m_ovf_d;
  logic [DATA_WIDTH-1:0] sat_data;
  logic                  sat_ovf;

  function automatic logic [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  // Clamp sits on the next-state accumulator so the result is captured on the DONE-entry edge.
  adder_sat #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat (
    .acc_i (acc_d),
    .data_o(sat_data),
    .ovf_o (sat_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ovf_d   = m_ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = sext(cfg_bias);
          rem_d   = cfg_count;
          busy_d  = 1'b1;
          state_d = (cfg_count == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (s_valid) begin
          acc_d = acc_q + sext(s_data);
          rem_d = rem_q - CNT_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE && state_q != DONE) begin
      m_valid_d = 1'b1;
      m_data_d  = sat_data;
      m_ovf_d   = sat_ovf;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ovf_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ovf_q   <= m_ovf_d;
    end
  end

  assign s_ready     = (state_q == ACCUM);
  assign busy        = busy_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_ovf       = m_ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adder_accum_core.sv
// Directed and randomized bench for adder_accum_core against an arithmetic reference model.
module tb_adder_accum_core;
  import adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [15:0] cfg_count;
  logic [31:0] cfg_bias;
  logic        start;
  logic        busy;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_ovf;
  logic [1:0]  dbg_state_o;

  always #5 ACLK = ~ACLK;

  adder_accum_core dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .cfg_count  (cfg_count),
    .cfg_bias   (cfg_bias),
    .start      (start),
    .busy       (busy),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_ovf      (m_ovf),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] ops_q[$];
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: exact integer sum of bias and operands, then clamp to 32-bit signed range.
  function automatic result_t ref_model(input logic [31:0] bias);
    longint  total;
    result_t r;
    total = longint'($signed(bias));
    foreach (ops_q[i]) total += longint'($signed(ops_q[i]));
    if (total > 64'sd2147483647) begin
      r.data = 32'h7FFF_FFFF; r.ovf = 1'b1;
    end else if (total < -64'sd2147483648) begin
      r.data = 32'h8000_0000; r.ovf = 1'b1;
    end else begin
      r.data = total[31:0];   r.ovf = 1'b0;
    end
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic do_run(input string tag, input logic [31:0] bias,
                        input int gap_lo, input int gap_hi, input int stall);
    int      count;
    result_t r;
    logic [32:0] e;
    count = ops_q.size();
    r = ref_model(bias);
    exp_q.push_back({r.data, r.ovf});
    cfg_bias  = bias;
    cfg_count = 16'(count);
    start     = 1'b1;
    m_ready   = (stall == 0);
    @(negedge ACLK);
    start     = 1'b0;
    cfg_bias  = $urandom;
    cfg_count = 16'($urandom);
    check({tag, "/busy_up"}, busy, 1);
    if (count == 0) check({tag, "/s_ready_zero"}, s_ready, 0);
    for (int i = 0; i < count; i++) begin
      int gap;
      gap = $urandom_range(gap_hi, gap_lo);
      repeat (gap) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        start   = 1'($urandom_range(1, 0));
        @(negedge ACLK);
      end
      start   = 1'b0;
      s_valid = 1'b1;
      s_data  = ops_q[i];
      check({tag, "/s_ready"}, s_ready, 1);
      check({tag, "/m_valid_early"}, m_valid, 0);
      @(negedge ACLK);
    end
    s_valid = 1'($urandom_range(1, 0));
    s_data  = $urandom;
    e = exp_q.pop_front();
    check({tag, "/m_valid"}, m_valid, 1);
    check({tag, "/m_data"}, m_data, e[32:1]);
    check({tag, "/m_ovf"}, m_ovf, e[0]);
    check({tag, "/s_ready_done"}, s_ready, 0);
    repeat (stall) begin
      start = 1'b1;
      @(negedge ACLK);
      check({tag, "/hold_valid"}, m_valid, 1);
      check({tag, "/hold_data"}, {m_ovf, m_data}, {e[0], e[32:1]});
    end
    m_ready = 1'b1;
    start   = 1'b1;
    @(negedge ACLK);
    start   = 1'b0;
    m_ready = 1'b0;
    s_valid = 1'b0;
    check({tag, "/m_valid_drop"}, m_valid, 0);
    check({tag, "/busy_drop"}, busy, 0);
    check({tag, "/data_kept"}, m_data, e[32:1]);
    @(negedge ACLK);
    check({tag, "/no_rerun"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ARESETN = 1'b0; cfg_count = '0; cfg_bias = '0; start = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(negedge ACLK);
    check("rst/busy", busy, 0);
    check("rst/m_valid", m_valid, 0);
    check("rst/m_data", m_data, 0);
    check("rst/m_ovf", m_ovf, 0);
    check("rst/s_ready", s_ready, 0);
    check("rst/state", dbg_state_o, IDLE);
    ARESETN = 1'b1;
    @(negedge ACLK);

    ops_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_run("t1_sum4", 32'd0, 0, 0, 0);
    ops_q = {};
    do_run("t2_zero", 32'hFFFF_FFFB, 0, 0, 0);
    ops_q = '{32'd1, 32'd1};
    do_run("t3_posclamp", 32'h7FFF_FFFF, 0, 0, 0);
    ops_q = '{32'hFFFF_FFFF};
    do_run("t3_negclamp", 32'h8000_0000, 0, 0, 0);
    ops_q = '{32'd1, 32'hFFFF_FFFF};
    do_run("t4_nowrap", 32'h7FFF_FFFF, 0, 0, 0);
    ops_q = '{32'd10, 32'd20, 32'd30};
    do_run("t5_gaps", 32'd0, 2, 2, 5);

    // Reset in the middle of a run drops the partial sum.
    cfg_bias = 32'd100; cfg_count = 16'd4; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0; s_valid = 1'b1; s_data = 32'd5;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b0; s_valid = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    check("t6/busy", busy, 0);
    check("t6/m_valid", m_valid, 0);
    check("t6/m_data", m_data, 0);
    check("t6/m_ovf", m_ovf, 0);
    check("t6/s_ready", s_ready, 0);
    repeat (3) @(negedge ACLK);
    check("t6/no_result", m_valid, 0);
    ops_q = '{32'd7};
    do_run("t6_after", 32'd0, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(8, 0);
      ops_q = {};
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(3, 0))
          0:       ops_q.push_back(32'h7FFF_FFFF);
          1:       ops_q.push_back(32'h8000_0000);
          default: ops_q.push_back($urandom);
        endcase
      end
      do_run($sformatf("rand%0d", r), $urandom, 0, 2, $urandom_range(3, 0));
    end

    // Largest count with most-negative values everywhere must not wrap.
    ops_q = {};
    for (int j = 0; j < 65535; j++) ops_q.push_back(32'h8000_0000);
    do_run("maxcount", 32'h8000_0000, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
